// File: rtl/mem_pkg.sv
// Shared memory-path definitions: store encodings, byte-enable width and the
// layout of one posted-write entry at the default 32-bit address/data widths.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } store_type_t;

    typedef struct packed {
        logic [WORD_W-1:0] word_addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } sb_entry_t;

endpackage

// File: rtl/sb_addr_match.sv
// Word-address comparator array: one comparator per buffer entry, qualified by
// the entry valid mask and OR-reduced into a single hit.
module sb_addr_match #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 30
) (
    input  logic [WORD_W-1:0] entry_word [DEPTH],
    input  logic [DEPTH-1:0]  entry_valid,
    input  logic [WORD_W-1:0] probe_word,
    output logic              hit
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entry_valid[i] && (entry_word[i] == probe_word);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: in-order FIFO of store beats drained to the data-memory
// write port, with a word-granular load/store conflict flag for the hazard unit.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [DATA_W/8-1:0]        st_be,
    input  logic                       ld_check,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_conflict,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_be,
    input  logic                       mem_ack,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BEW   = DATA_W / 8;
    localparam int WW    = ADDR_W - 2;

    logic [WW-1:0]     word_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BEW-1:0]    be_q   [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic full, empty, accept, push, pop, entry_hit, beat_hit;
    logic unused_low_bits;

    // Handshakes: a store beat transfers on st_valid && st_ready; a memory write
    // completes on mem_req && mem_ack. Neither side may retract an offer, and the
    // head entry is held stable while mem_req is high without mem_ack.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full && !rst;
    assign accept   = st_valid && st_ready;
    assign push     = accept && (|st_be);
    assign pop      = !empty && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; outputs are gated by empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= st_addr[ADDR_W-1:2];
            data_q[wr_ptr] <= st_data;
            be_q[wr_ptr]   <= st_be;
        end
    end

    assign mem_req   = !empty;
    assign mem_addr  = empty ? '0 : {word_q[rd_ptr], 2'b00};
    assign mem_wdata = empty ? '0 : data_q[rd_ptr];
    assign mem_be    = empty ? '0 : be_q[rd_ptr];
    assign sb_empty  = empty;
    assign sb_count  = count;

    sb_addr_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WW)
    ) u_match (
        .entry_word  (word_q),
        .entry_valid (valid_q),
        .probe_word  (ld_addr[ADDR_W-1:2]),
        .hit         (entry_hit)
    );

    assign beat_hit    = push && (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    assign ld_conflict = ld_check && (entry_hit || beat_hit);

    assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with DEPTH 4: reset, drain latency, full
// back-pressure, load conflicts, push/pop overlap, wrap, zero-BE beats, reset.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .ld_check    (ld_check),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .sb_empty    (sb_empty),
        .sb_count    (sb_count)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
    endtask

    task automatic idle_store();
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_be    = '0;
    endtask

    initial begin
        rst      = 1'b1;
        mem_ack  = 1'b0;
        ld_check = 1'b0;
        ld_addr  = '0;
        idle_store();
        tick();
        tick();

        // reset state
        ld_check = 1'b1;
        chk("rst_st_ready", 64'(st_ready), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_ld_conflict", 64'(ld_conflict), 64'd0);
        chk("rst_sb_empty", 64'(sb_empty), 64'd1);
        chk("rst_sb_count", 64'(sb_count), 64'd0);
        ld_check = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_st_ready", 64'(st_ready), 64'd1);

        // single SW with mem_ack tied high
        mem_ack = 1'b1;
        drive_store(32'h1000, 32'hDEADBEEF, 4'hF);
        ld_check = 1'b1;
        ld_addr  = 32'h1000;
        #1;
        chk("beat_conflict", 64'(ld_conflict), 64'd1);
        tick();
        idle_store();
        ld_check = 1'b0;
        chk("sw_mem_req", 64'(mem_req), 64'd1);
        chk("sw_mem_addr", 64'(mem_addr), 64'h1000);
        chk("sw_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("sw_mem_be", 64'(mem_be), 64'hF);
        chk("sw_count", 64'(sb_count), 64'd1);
        tick();
        chk("sw_drained_empty", 64'(sb_empty), 64'd1);
        chk("sw_drained_req", 64'(mem_req), 64'd0);

        // fill to DEPTH with mem_ack low, fifth beat refused
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            exp_q.push_back({32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});
            tick();
        end
        drive_store(32'h110, 32'hBAD, 4'hF);
        #1;
        chk("full_st_ready", 64'(st_ready), 64'd0);
        chk("full_count", 64'(sb_count), 64'd4);
        tick();
        idle_store();
        chk("fifth_refused_count", 64'(sb_count), 64'd4);
        chk("held_head_addr", 64'(mem_addr), 64'h100);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_e = exp_q.pop_front();
            chk("drain_addr", 64'(mem_addr), 64'(exp_e[63:32]));
            chk("drain_data", 64'(mem_wdata), 64'(exp_e[31:0]));
            tick();
        end
        chk("drain_empty", 64'(sb_empty), 64'd1);

        // load conflict on a pending SB, word granularity
        mem_ack = 1'b0;
        drive_store(32'h2003, 32'hAAAAAAAA, 4'b1000);
        tick();
        idle_store();
        ld_check = 1'b1;
        ld_addr  = 32'h2000;
        #1;
        chk("ld_same_word", 64'(ld_conflict), 64'd1);
        ld_addr = 32'h2004;
        #1;
        chk("ld_next_word", 64'(ld_conflict), 64'd0);
        ld_check = 1'b0;
        ld_addr  = 32'h2000;
        #1;
        chk("ld_no_check", 64'(ld_conflict), 64'd0);
        chk("sb_be", 64'(mem_be), 64'h8);

        // push and pop together at count 2; popped entry still conflicts
        drive_store(32'h3000, 32'h33, 4'hF);
        tick();
        drive_store(32'h4000, 32'h44, 4'hF);
        mem_ack  = 1'b1;
        ld_check = 1'b1;
        ld_addr  = 32'h2001;
        #1;
        chk("pop_entry_conflict", 64'(ld_conflict), 64'd1);
        chk("pre_overlap_count", 64'(sb_count), 64'd2);
        tick();
        idle_store();
        ld_check = 1'b0;
        chk("overlap_count", 64'(sb_count), 64'd2);
        chk("overlap_head", 64'(mem_addr), 64'h3000);
        tick();
        chk("overlap_next_head", 64'(mem_wdata), 64'h44);
        tick();
        chk("overlap_drained", 64'(sb_empty), 64'd1);

        // 10 continuous transfers across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive_store(32'h5000 + 32'(4 * i), 32'h500 + 32'(i), 4'hF);
            tick();
            chk("wrap_head", 64'(mem_addr), 64'h5000 + 64'(4 * i));
            chk("wrap_count", 64'(sb_count), 64'd1);
        end
        idle_store();
        tick();
        chk("wrap_empty", 64'(sb_empty), 64'd1);

        // zero byte-enable beat is accepted but not stored
        mem_ack = 1'b0;
        drive_store(32'h6000, 32'h66, 4'h0);
        #1;
        chk("be0_ready", 64'(st_ready), 64'd1);
        tick();
        idle_store();
        chk("be0_count", 64'(sb_count), 64'd0);
        chk("be0_req", 64'(mem_req), 64'd0);

        // reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h7000 + 32'(4 * i), 32'h70 + 32'(i), 4'hF);
            tick();
        end
        idle_store();
        chk("pre_rst_count", 64'(sb_count), 64'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_count", 64'(sb_count), 64'd0);
        chk("mid_rst_empty", 64'(sb_empty), 64'd1);
        rst     = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("after_rst_req", 64'(mem_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
